// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the uart_tx arbiter.
// Build option: UART_ARB_BREAK_EN adds the BREAK state to the state enum.
package uart_arb_pkg;

`ifdef UART_ARB_BREAK_EN
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, BREAK, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, GAP} state_t;
`endif

  typedef logic [7:0] byte_t;

  localparam int DEF_N_REQ         = 4;
  localparam int DEF_TIMEOUT_BAUDS = 64;
  localparam int DEF_GAP_BAUDS     = 2;
  localparam int DEF_BREAK_BAUDS   = 12;

  // Counter width able to hold 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after ptr_i, with wrap.
module uart_rr_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = $clog2(DEF_N_REQ)
)(
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  // Walk from ptr_i+1 around the ring and keep the first hit.
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ packet sources; owns the THR feeding uart_tx.
// Build option: UART_ARB_BREAK_EN inserts a timed line break after each packet.
//
// state  | meaning
// IDLE   | no owner, waiting for any req_valid
// STREAM | owner granted, bytes move into the THR
// DRAIN  | packet ended or timed out, waiting for THR and shifter to empty
// BREAK  | set_break held for BREAK_BAUDS ticks (UART_ARB_BREAK_EN only)
// GAP    | idle line for GAP_BAUDS ticks before the next grant
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int TIMEOUT_BAUDS = DEF_TIMEOUT_BAUDS,
  parameter int GAP_BAUDS     = DEF_GAP_BAUDS
`ifdef UART_ARB_BREAK_EN
  , parameter int BREAK_BAUDS = DEF_BREAK_BAUDS
`endif
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_pulse_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic               pop_i,
  input  logic               sreg_empty_i,
  output logic [7:0]         din_o,
  output logic               thre_o,
  output logic               set_break_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic [N_REQ-1:0]   timeout_err_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = cnt_w(TIMEOUT_BAUDS);
  localparam int GW = cnt_w(GAP_BAUDS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_BAUDS - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_BAUDS);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_BAUDS - 1);

  state_t           state_q;
  logic [N_REQ-1:0] grant_q, tout_q;
  logic [PW-1:0]    ptr_q;
  logic             thr_full_q, pop_prev_q;
  byte_t            din_q;
  logic [TW-1:0]    stall_q;
  logic [GW-1:0]    gap_q;

  logic [N_REQ-1:0] rr_grant;
  logic [PW-1:0]    rr_idx;
  logic             rr_any;
  logic             accept, cur_valid, cur_last, drain_done;
  byte_t            cur_data;

  uart_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // The pointer holds the owner's index for the whole packet.
  assign cur_valid   = req_valid_i[ptr_q];
  assign cur_last    = req_last_i[ptr_q];
  assign cur_data    = req_data_i[int'(ptr_q)*8 +: 8];
  assign req_ready_o = grant_q & {N_REQ{(state_q == STREAM) && (!thr_full_q || pop_i)}};
  assign accept      = |(req_valid_i & req_ready_o);
  // Two quiet pop cycles guard against a pop racing the sreg_empty flag.
  assign drain_done  = !thr_full_q && sreg_empty_i && !pop_i && !pop_prev_q;

  assign din_o         = din_q;
  assign thre_o        = ~thr_full_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = tout_q;

  // THR: a load wins over a simultaneous pop so the new byte is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      thr_full_q <= 1'b0;
      din_q      <= '0;
      pop_prev_q <= 1'b0;
    end else begin
      pop_prev_q <= pop_i;
      if (accept) begin
        thr_full_q <= 1'b1;
        din_q      <= cur_data;
      end else if (pop_i) begin
        thr_full_q <= 1'b0;
      end
    end
  end

`ifdef UART_ARB_BREAK_EN
  localparam int BW = cnt_w(BREAK_BAUDS);
  localparam logic [BW-1:0] B_LAST = BW'(BREAK_BAUDS - 1);
  logic [BW-1:0] brk_q;
  logic          set_break_q;
  assign set_break_o = set_break_q;
`else
  assign set_break_o = 1'b0;
`endif

  // Packet sequencing: grant, stall timeout, drain, optional break, gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      tout_q  <= '0;
      stall_q <= '0;
      gap_q   <= '0;
`ifdef UART_ARB_BREAK_EN
      brk_q       <= '0;
      set_break_q <= 1'b0;
`endif
    end else begin
      tout_q <= '0;
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            grant_q <= rr_grant;
            ptr_q   <= rr_idx;
            stall_q <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            stall_q <= '0;
            if (cur_last) state_q <= DRAIN;
          end else if (baud_pulse_i && !thr_full_q && !cur_valid) begin
            if (stall_q == T_LAST) begin
              tout_q  <= grant_q;
              stall_q <= T_MAX;
              state_q <= DRAIN;
            end else begin
              stall_q <= stall_q + TW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            grant_q <= '0;
            gap_q   <= '0;
`ifdef UART_ARB_BREAK_EN
            brk_q       <= '0;
            set_break_q <= 1'b1;
            state_q     <= BREAK;
`else
            state_q <= (GAP_BAUDS == 0) ? IDLE : GAP;
`endif
          end
        end
`ifdef UART_ARB_BREAK_EN
        BREAK: begin
          if (baud_pulse_i) begin
            if (brk_q == B_LAST) begin
              set_break_q <= 1'b0;
              state_q     <= (GAP_BAUDS == 0) ? IDLE : GAP;
            end else begin
              brk_q <= brk_q + BW'(1);
            end
          end
        end
`endif
        GAP: begin
          if (baud_pulse_i) begin
            if (gap_q == G_LAST) state_q <= IDLE;
            else                 gap_q   <= gap_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (defaults: N_REQ=4, TIMEOUT=64, GAP=2).
// Build option: UART_ARB_BREAK_EN enables the break-length checks.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        baud_pulse = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        pop = 1'b0;
  logic        sreg_empty = 1'b1;
  logic [7:0]  din;
  logic        thre, set_break, busy;
  logic [3:0]  grant, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse_i  (baud_pulse),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .pop_i         (pop),
    .sreg_empty_i  (sreg_empty),
    .din_o         (din),
    .thre_o        (thre),
    .set_break_o   (set_break),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic baud();
    baud_pulse = 1'b1;
    cyc(1);
    baud_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; req_last = '0; pop = 1'b0; sreg_empty = 1'b1;
    cyc(2);
    rst = 1'b1;
  endtask

  // Post-packet wait: optional break, then the 2-tick gap.
  task automatic finish_gap();
`ifdef UART_ARB_BREAK_EN
    repeat (12) baud();
`endif
    baud();
    baud();
  endtask

  // One 1-byte packet from requester idx; data byte is 0x10+idx.
  task automatic pkt1(input int idx);
    logic [3:0] e;
    e = 4'b0001 << idx;
    cyc(1);
    chk("rr_grant", grant, e);
    cyc(1);
    chk("rr_din", din, 8'h10 + idx);
    req_valid[idx] = 1'b0;
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    cyc(2);
    chk("rr_release", grant, 4'b0000);
    finish_gap();
    chk("rr_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(2);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_thre", thre, 1'b1);
    chk("rst_din", din, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tout", timeout_err, 4'b0000);
    chk("rst_break", set_break, 1'b0);
    rst = 1'b1;
    cyc(1);

    // Single requester: 0x13, 0x55, 0xA0(last)
    req_valid = 4'b0001; req_data[7:0] = 8'h13; req_last = 4'b0000;
    cyc(1);
    chk("s_grant", grant, 4'b0001);
    #1 chk("s_ready", req_ready, 4'b0001);
    cyc(1);
    chk("s_din0", din, 8'h13);
    chk("s_thre0", thre, 1'b0);
    req_valid = 4'b0000; req_data[7:0] = 8'h55;
    #1 chk("s_ready_full", req_ready, 4'b0000);
    pop = 1'b1; sreg_empty = 1'b0;
    cyc(1);
    pop = 1'b0;
    chk("s_thre_pop0", thre, 1'b1);
    req_valid = 4'b0001;
    cyc(1);
    chk("s_din1", din, 8'h55);
    chk("s_thre1", thre, 1'b0);
    req_valid = 4'b0000; pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    chk("s_thre_pop1", thre, 1'b1);
    req_valid = 4'b0001; req_data[7:0] = 8'hA0; req_last = 4'b0001;
    cyc(1);
    chk("s_din2", din, 8'hA0);
    req_valid = 4'b0000; req_last = 4'b0000;
    #1 chk("s_ready_drain", req_ready, 4'b0000);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    cyc(3);
    chk("s_hold_grant", grant, 4'b0001);
    sreg_empty = 1'b1;
    cyc(1);
    chk("s_release", grant, 4'b0000);
    chk("s_busy_gap", busy, 1'b1);
`ifdef UART_ARB_BREAK_EN
    chk("brk_on", set_break, 1'b1);
    repeat (11) baud();
    chk("brk_held", set_break, 1'b1);
    baud();
    chk("brk_off", set_break, 1'b0);
    chk("brk_gap_busy", busy, 1'b1);
`endif
    cyc(3);
    chk("s_gap_hold", busy, 1'b1);
    baud();
    chk("s_gap1", busy, 1'b1);
    baud();
    chk("s_gap2_idle", busy, 1'b0);

    // Contention: two rounds of all four requesters
    do_reset();
    req_data = 32'h13121110; req_last = 4'b1111;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) pkt1(i);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) pkt1(i);
    req_last = '0;

    // Simultaneous pop and load: 0x01, 0x02
    do_reset();
    req_valid = 4'b0001; req_data[7:0] = 8'h01;
    cyc(1);
    cyc(1);
    chk("pl_din0", din, 8'h01);
    req_data[7:0] = 8'h02; req_last = 4'b0001;
    #1 chk("pl_ready_full", req_ready, 4'b0000);
    cyc(1);
    chk("pl_din_hold", din, 8'h01);
    pop = 1'b1;
    #1 chk("pl_ready_pop", req_ready, 4'b0001);
    cyc(1);
    pop = 1'b0; req_valid = 4'b0000; req_last = 4'b0000;
    chk("pl_din1", din, 8'h02);
    chk("pl_thre", thre, 1'b0);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    chk("pl_thre_empty", thre, 1'b1);
    cyc(2);
    chk("pl_release", grant, 4'b0000);
    finish_gap();
    chk("pl_idle", busy, 1'b0);

    // Stall timeout on requester 2
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'h77;
    cyc(1);
    chk("to_grant", grant, 4'b0100);
    cyc(1);
    req_valid = 4'b0000;
    chk("to_din", din, 8'h77);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    repeat (63) baud();
    chk("to_early", timeout_err, 4'b0000);
    chk("to_grant_held", grant, 4'b0100);
    baud();
    chk("to_pulse", timeout_err, 4'b0100);
    cyc(1);
    chk("to_pulse_end", timeout_err, 4'b0000);
    chk("to_release", grant, 4'b0000);
    chk("to_busy", busy, 1'b1);
    finish_gap();
    chk("to_idle", busy, 1'b0);

    // Reset mid-packet on requester 2, then req1/req3 contend
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'hAA;
    cyc(1);
    cyc(1);
    req_data[23:16] = 8'hBB; pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    chk("mr_din1", din, 8'hBB);
    rst = 1'b0;
    cyc(1);
    chk("mr_grant", grant, 4'b0000);
    chk("mr_thre", thre, 1'b1);
    chk("mr_din", din, 8'h00);
    chk("mr_busy", busy, 1'b0);
    rst = 1'b1;
    req_valid = 4'b1010;
    cyc(1);
    chk("mr_regrant", grant, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
